// File: rtl/change_dispenser_if.sv
// change_dispenser_if: request/status bundle between the vending core and
// the change dispenser.
//   change_valid_i, change_i, refill_i : request side (driven by master)
//   busy_o, eject_*_o, done_o, short_o,
//   drop_o, *_cnt_o                    : status side (driven by dispenser)
// Signal names keep the block's documented port names so waveforms and
// the datasheet line up.
interface change_dispenser_if #(
    parameter int CNT_W = 4
);
    logic             change_valid_i;
    logic [2:0]       change_i;
    logic             refill_i;
    logic             busy_o;
    logic             eject_nickel_o;
    logic             eject_dime_o;
    logic             eject_quarter_o;
    logic             done_o;
    logic             short_o;
    logic             drop_o;
    logic [CNT_W-1:0] nickel_cnt_o;
    logic [CNT_W-1:0] dime_cnt_o;
    logic [CNT_W-1:0] quarter_cnt_o;

    modport master (
        output change_valid_i, change_i, refill_i,
        input  busy_o, eject_nickel_o, eject_dime_o, eject_quarter_o,
               done_o, short_o, drop_o, nickel_cnt_o, dime_cnt_o, quarter_cnt_o
    );

    modport slave (
        input  change_valid_i, change_i, refill_i,
        output busy_o, eject_nickel_o, eject_dime_o, eject_quarter_o,
               done_o, short_o, drop_o, nickel_cnt_o, dime_cnt_o, quarter_cnt_o
    );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: pays out one change request (in nickels) as coins using
// greedy quarter/dime/nickel selection, one timed solenoid pulse per coin,
// and tracks the remaining coin count of each tube.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous reset, active-high
//   bus    : change_dispenser_if.slave (request in, solenoids/status/counts out)
// All outputs come straight from flops.
module change_dispenser #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int CNT_W        = 4,
    parameter int NICKEL_INIT  = 8,
    parameter int DIME_INIT    = 8,
    parameter int QUARTER_INIT = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    change_dispenser_if.slave  bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] SELECT = 3'd1;
    localparam logic [2:0] PULSE  = 3'd2;
    localparam logic [2:0] GAP    = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    localparam int TMAX  = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TMR_W = $clog2(TMAX) + 1;

    localparam logic [CNT_W-1:0] N_INIT = CNT_W'(NICKEL_INIT);
    localparam logic [CNT_W-1:0] D_INIT = CNT_W'(DIME_INIT);
    localparam logic [CNT_W-1:0] Q_INIT = CNT_W'(QUARTER_INIT);

    logic [2:0]       state;
    logic [2:0]       remaining;
    logic [TMR_W-1:0] timer;     // counts down to 0 within PULSE / GAP
    logic [CNT_W-1:0] n_cnt, d_cnt, q_cnt;
    logic             ej_n, ej_d, ej_q;
    logic             busy, done, short_r, drop;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            remaining <= '0;
            timer     <= '0;
            n_cnt     <= N_INIT;
            d_cnt     <= D_INIT;
            q_cnt     <= Q_INIT;
            ej_n      <= 1'b0;
            ej_d      <= 1'b0;
            ej_q      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            short_r   <= 1'b0;
            drop      <= 1'b0;
        end else begin
            // A request that shows up while we are working is lost; flag it.
            drop <= bus.change_valid_i && (state != IDLE);

            case (state)
                IDLE: begin
                    // Refill and request in the same cycle are both taken;
                    // SELECT then sees the reloaded counts.
                    if (bus.refill_i) begin
                        n_cnt <= N_INIT;
                        d_cnt <= D_INIT;
                        q_cnt <= Q_INIT;
                    end
                    if (bus.change_valid_i) begin
                        remaining <= bus.change_i;
                        state     <= SELECT;
                        busy      <= 1'b1;
                    end
                end

                SELECT: begin
                    timer <= TMR_W'(PULSE_CYCLES - 1);
                    if (remaining == 3'd0) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        short_r <= 1'b0;
                    end else if (remaining >= 3'd5 && q_cnt != '0) begin
                        q_cnt     <= q_cnt - 1'b1;
                        remaining <= remaining - 3'd5;
                        ej_q      <= 1'b1;
                        state     <= PULSE;
                    end else if (remaining >= 3'd2 && d_cnt != '0) begin
                        d_cnt     <= d_cnt - 1'b1;
                        remaining <= remaining - 3'd2;
                        ej_d      <= 1'b1;
                        state     <= PULSE;
                    end else if (n_cnt != '0) begin
                        // remaining >= 1 is implied by the first branch
                        n_cnt     <= n_cnt - 1'b1;
                        remaining <= remaining - 3'd1;
                        ej_n      <= 1'b1;
                        state     <= PULSE;
                    end else begin
                        // Tubes cannot make the remainder.
                        state   <= DONE;
                        done    <= 1'b1;
                        short_r <= 1'b1;
                    end
                end

                PULSE: begin
                    if (timer == '0) begin
                        ej_n  <= 1'b0;
                        ej_d  <= 1'b0;
                        ej_q  <= 1'b0;
                        timer <= TMR_W'(GAP_CYCLES - 1);
                        state <= GAP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end

                GAP: begin
                    if (timer == '0) state <= SELECT;
                    else             timer <= timer - 1'b1;
                end

                DONE: begin
                    done    <= 1'b0;
                    short_r <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    state   <= IDLE;
                    ej_n    <= 1'b0;
                    ej_d    <= 1'b0;
                    ej_q    <= 1'b0;
                    done    <= 1'b0;
                    short_r <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o          = busy;
    assign bus.eject_nickel_o  = ej_n;
    assign bus.eject_dime_o    = ej_d;
    assign bus.eject_quarter_o = ej_q;
    assign bus.done_o          = done;
    assign bus.short_o         = short_r;
    assign bus.drop_o          = drop;
    assign bus.nickel_cnt_o    = n_cnt;
    assign bus.dime_cnt_o      = d_cnt;
    assign bus.quarter_cnt_o   = q_cnt;
endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser. Three instances share clk/rst:
//   0: defaults, 1: QUARTER_INIT=0, 2: NICKEL_INIT=0.
// Cycle numbering: the edge that samples the request is edge 0; values
// seen just after edge k-1 belong to cycle k.
module tb_change_dispenser;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] v  = '0;
    logic [2:0] rf = '0;
    logic [2:0] chg [3];

    logic [2:0] busy_w, ejn_w, ejd_w, ejq_w, done_w, short_w, drop_w;
    logic [3:0] ncnt_w [3];
    logic [3:0] dcnt_w [3];
    logic [3:0] qcnt_w [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NI = (g == 2) ? 0 : 8;
        localparam int QI = (g == 1) ? 0 : 4;
        change_dispenser_if #(.CNT_W(4)) bus ();
        change_dispenser #(
            .PULSE_CYCLES(4), .GAP_CYCLES(2), .CNT_W(4),
            .NICKEL_INIT(NI), .DIME_INIT(8), .QUARTER_INIT(QI)
        ) u_dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus.slave)
        );
        assign bus.change_valid_i = v[g];
        assign bus.change_i       = chg[g];
        assign bus.refill_i       = rf[g];
        assign busy_w[g]  = bus.busy_o;
        assign ejn_w[g]   = bus.eject_nickel_o;
        assign ejd_w[g]   = bus.eject_dime_o;
        assign ejq_w[g]   = bus.eject_quarter_o;
        assign done_w[g]  = bus.done_o;
        assign short_w[g] = bus.short_o;
        assign drop_w[g]  = bus.drop_o;
        assign ncnt_w[g]  = bus.nickel_cnt_o;
        assign dcnt_w[g]  = bus.dime_cnt_o;
        assign qcnt_w[g]  = bus.quarter_cnt_o;
    end

    int n_cmp = 0;
    int n_bad = 0;

    // trace of the last run, indexed by cycle
    logic tr_n [64];
    logic tr_d [64];
    logic tr_q [64];
    logic tr_drop [64];
    int   tr_viol;   // non-one-hot ejects or short without done

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one request on instance d. If inj > 0, a second request (with
    // refill) is driven during cycle inj. rfs asserts refill with the request.
    task automatic run_req(input int d, input logic [2:0] ch, input int inj,
                           input logic rfs, output int done_cyc,
                           output int sh, output int busy_after);
        int c;
        done_cyc   = -1;
        sh         = -1;
        busy_after = -1;
        tr_viol    = 0;
        for (int i = 0; i < 64; i++) begin
            tr_n[i] = 0; tr_d[i] = 0; tr_q[i] = 0; tr_drop[i] = 0;
        end
        @(negedge clk);
        v[d] = 1'b1; chg[d] = ch; rf[d] = rfs;
        @(posedge clk); #1;
        v[d] = 1'b0; rf[d] = 1'b0;
        for (c = 1; c < 60; c++) begin
            tr_n[c]    = ejn_w[d];
            tr_d[c]    = ejd_w[d];
            tr_q[c]    = ejq_w[d];
            tr_drop[c] = drop_w[d];
            if ((32'(ejn_w[d]) + 32'(ejd_w[d]) + 32'(ejq_w[d])) > 1) tr_viol++;
            if (short_w[d] && !done_w[d]) tr_viol++;
            if (done_w[d] && done_cyc < 0) begin
                done_cyc = c;
                sh       = 32'(short_w[d]);
            end
            if (done_cyc > 0 && c == done_cyc + 1) begin
                busy_after = 32'(busy_w[d]);
                break;
            end
            if (c == inj) begin
                v[d] = 1'b1; chg[d] = 3'd7; rf[d] = 1'b1;
            end
            @(posedge clk); #1;
            v[d] = 1'b0; rf[d] = 1'b0;
        end
        if (done_cyc < 0) chk("done_timeout", 0, 1);
    endtask

    function automatic int cnt_hi(input logic tr [64]);
        int s = 0;
        for (int i = 0; i < 64; i++) s += 32'(tr[i]);
        return s;
    endfunction

    typedef struct {
        int         d;
        logic [2:0] ch;
        int         done_cyc;
        int         sh;
        int         n, dm, q;   // counts after the run
    } vec_t;

    vec_t vt [11];
    int ninit [3] = '{8, 8, 0};
    int dinit [3] = '{8, 8, 8};
    int qinit [3] = '{4, 0, 4};

    initial begin
        int dc, sh, ba;
        for (int i = 0; i < 3; i++) chg[i] = '0;

        vt[0]  = '{0, 3'd0,  2, 0, 8, 8, 4};
        vt[1]  = '{0, 3'd3, 16, 0, 7, 7, 4};
        vt[2]  = '{0, 3'd7, 16, 0, 8, 7, 3};
        vt[3]  = '{0, 3'd5,  9, 0, 8, 8, 3};
        vt[4]  = '{0, 3'd6, 16, 0, 7, 8, 3};
        vt[5]  = '{0, 3'd4, 16, 0, 8, 6, 4};
        vt[6]  = '{1, 3'd5, 23, 0, 7, 6, 0};
        vt[7]  = '{1, 3'd7, 30, 0, 7, 5, 0};
        vt[8]  = '{2, 3'd1,  2, 1, 0, 8, 4};
        vt[9]  = '{2, 3'd3,  9, 1, 0, 7, 4};
        vt[10] = '{2, 3'd2,  9, 0, 0, 7, 4};

        // reset state
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk("rst_busy",  32'(busy_w[g]), 0);
            chk("rst_eject", 32'(ejn_w[g]) + 32'(ejd_w[g]) + 32'(ejq_w[g]), 0);
            chk("rst_flags", 32'(done_w[g]) + 32'(short_w[g]) + 32'(drop_w[g]), 0);
            chk("rst_ncnt",  32'(ncnt_w[g]), ninit[g]);
            chk("rst_dcnt",  32'(dcnt_w[g]), dinit[g]);
            chk("rst_qcnt",  32'(qcnt_w[g]), qinit[g]);
        end
        rst = 1'b0;

        // table
        for (int i = 0; i < 11; i++) begin
            int d;
            d = vt[i].d;
            do_reset();
            run_req(d, vt[i].ch, 0, 1'b0, dc, sh, ba);
            chk($sformatf("v%0d_done_cyc", i), dc, vt[i].done_cyc);
            chk($sformatf("v%0d_short", i), sh, vt[i].sh);
            chk($sformatf("v%0d_busy_after", i), ba, 0);
            chk($sformatf("v%0d_ncnt", i), 32'(ncnt_w[d]), vt[i].n);
            chk($sformatf("v%0d_dcnt", i), 32'(dcnt_w[d]), vt[i].dm);
            chk($sformatf("v%0d_qcnt", i), 32'(qcnt_w[d]), vt[i].q);
            chk($sformatf("v%0d_n_pulse", i), cnt_hi(tr_n), (ninit[d] - vt[i].n) * 4);
            chk($sformatf("v%0d_d_pulse", i), cnt_hi(tr_d), (dinit[d] - vt[i].dm) * 4);
            chk($sformatf("v%0d_q_pulse", i), cnt_hi(tr_q), (qinit[d] - vt[i].q) * 4);
            chk($sformatf("v%0d_viol", i), tr_viol, 0);
            chk($sformatf("v%0d_drop", i), cnt_hi(tr_drop), 0);
        end

        // change=3 with a second request + refill during cycle 4
        do_reset();
        run_req(0, 3'd3, 4, 1'b0, dc, sh, ba);
        begin
            int bd, bn, bq, bdrop;
            bd = 0; bn = 0; bq = 0; bdrop = 0;
            for (int c = 1; c <= 16; c++) begin
                if (32'(tr_d[c]) != ((c >= 2 && c <= 5) ? 1 : 0))  bd++;
                if (32'(tr_n[c]) != ((c >= 9 && c <= 12) ? 1 : 0)) bn++;
                if (tr_q[c]) bq++;
                if (32'(tr_drop[c]) != ((c == 5) ? 1 : 0)) bdrop++;
            end
            chk("busy_dime_trace", bd, 0);
            chk("busy_nickel_trace", bn, 0);
            chk("busy_quarter_trace", bq, 0);
            chk("busy_drop_trace", bdrop, 0);
        end
        chk("busy_done_cyc", dc, 16);
        chk("busy_short", sh, 0);
        chk("busy_ncnt_refill_ignored", 32'(ncnt_w[0]), 7);
        chk("busy_dcnt_refill_ignored", 32'(dcnt_w[0]), 7);
        // refill now in IDLE
        @(negedge clk); rf[0] = 1'b1;
        @(posedge clk); #1; rf[0] = 1'b0;
        chk("idle_refill_ncnt", 32'(ncnt_w[0]), 8);
        chk("idle_refill_dcnt", 32'(dcnt_w[0]), 8);

        // refill and request in the same cycle (QUARTER_INIT=0 instance)
        do_reset();
        run_req(1, 3'd5, 0, 1'b0, dc, sh, ba);   // leaves n7 d6
        run_req(1, 3'd7, 0, 1'b1, dc, sh, ba);   // reloaded: 3 dimes + nickel
        chk("rfreq_done_cyc", dc, 30);
        chk("rfreq_ncnt", 32'(ncnt_w[1]), 7);
        chk("rfreq_dcnt", 32'(dcnt_w[1]), 5);

        // reset during a quarter pulse
        do_reset();
        @(negedge clk); v[0] = 1'b1; chg[0] = 3'd7;
        @(posedge clk); #1; v[0] = 1'b0;
        @(posedge clk); @(posedge clk); #1;       // cycle 3
        chk("midrst_q_before", 32'(ejq_w[0]), 1);
        chk("midrst_qcnt_before", 32'(qcnt_w[0]), 3);
        #2 rst = 1'b1;
        #1;
        chk("midrst_q_eject", 32'(ejq_w[0]), 0);
        chk("midrst_busy", 32'(busy_w[0]), 0);
        chk("midrst_ncnt", 32'(ncnt_w[0]), 8);
        chk("midrst_dcnt", 32'(dcnt_w[0]), 8);
        chk("midrst_qcnt", 32'(qcnt_w[0]), 4);
        @(negedge clk); rst = 1'b0;
        run_req(0, 3'd3, 0, 1'b0, dc, sh, ba);
        chk("postrst_done_cyc", dc, 16);
        chk("postrst_short", sh, 0);
        chk("postrst_ncnt", 32'(ncnt_w[0]), 7);
        chk("postrst_dcnt", 32'(dcnt_w[0]), 7);
        chk("postrst_qcnt", 32'(qcnt_w[0]), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
